mem_wb_hilo: RTL and testbench
==============================

Name: mem_wb_hilo

Overview:
- Consumer end of the MEM-stage writeback interface.
- Registers the MEM-stage result bundle into the WB stage, honouring the pipeline stall vector (hold or insert a bubble).
- Owns the architectural HI/LO register pair, updated from the WB-stage bundle, and exposes HI/LO read values to EX.
- Keeps a retired-write counter for debug.

Parameters:
- REG_ADDR_W, 5, width of register-file write address.
- DATA_W, 32, width of register, HI and LO data.
- CNT_W, 32, width of the retired-write counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high (1 = reset).
- stall  in  6  pipeline stall vector; bit4 = MEM stalled, bit5 = WB stalled; 1 = Stop.
- mem_wd  in  REG_ADDR_W  MEM-stage destination register address.
- mem_wreg  in  1  MEM-stage register write enable.
- mem_wdata  in  DATA_W  MEM-stage register write data.
- mem_hi  in  DATA_W  MEM-stage HI write value.
- mem_lo  in  DATA_W  MEM-stage LO write value.
- mem_whilo  in  1  MEM-stage HI/LO write enable.
- wb_wd  out  REG_ADDR_W  WB-stage destination address, to regfile write port.
- wb_wreg  out  1  WB-stage register write enable.
- wb_wdata  out  DATA_W  WB-stage write data.
- wb_hi  out  DATA_W  WB-stage HI value, also forwarded to EX.
- wb_lo  out  DATA_W  WB-stage LO value, also forwarded to EX.
- wb_whilo  out  1  WB-stage HI/LO write enable.
- hi_o  out  DATA_W  architectural HI.
- lo_o  out  DATA_W  architectural LO.
- retire_cnt  out  CNT_W  count of WB cycles with wb_wreg or wb_whilo set.

Behaviour:
- All state is registered on rising clk. rst is sampled only at the clock edge, with no asynchronous path.
- Reset values, all outputs:
  - wb_wd = 0, wb_wreg = 0, wb_wdata = 0.
  - wb_hi = 0, wb_lo = 0, wb_whilo = 0.
  - hi_o = 0, lo_o = 0, retire_cnt = 0.
- Pipeline register, priority order per edge:
  1. rst = 1: reset values.
  2. stall[4] = 1 and stall[5] = 0: load a bubble. All wb_* outputs go to 0, so write enables are 0.
  3. stall[4] = 0: load the mem_* inputs into the wb_* outputs. Latency is 1 cycle.
  4. Otherwise (stall[4] = 1 and stall[5] = 1): hold all wb_* outputs.
- stall[3:0] is ignored.
- HI/LO storage:
  - On an edge with rst = 0 and wb_whilo = 1 (the registered value), hi_o <= wb_hi and lo_o <= wb_lo. Otherwise hold.
  - The write uses the current WB contents, not the incoming mem_* bundle. A bundle therefore reaches hi_o/lo_o 2 edges after it is presented at mem_*.
  - HI/LO updates are independent of stall. The WB stage is never stalled by the controller, so the write happens once per retired bundle.
  - If stall[5] = 1 holds a bundle with wb_whilo = 1, HI/LO is rewritten with identical values each cycle. This is idempotent and permitted.
- retire_cnt:
  - Increments by 1 on each edge with rst = 0 and (wb_wreg | wb_whilo) = 1, and stall[5] = 0.
  - Wraps from all-ones to 0 with no saturation.
  - A bubble never counts. A held bundle under stall[5] = 1 counts only once, on the edge where stall[5] is 0.
- Simultaneous events:
  - Reset mid-stall clears everything, including a held bundle and HI/LO.
  - A new bundle loading into WB on the same edge HI/LO writes the old WB bundle is the normal case, with no conflict.
- wb_hi, wb_lo and wb_whilo are exported unmodified so EX can forward from WB ahead of hi_o/lo_o.

Optional Feature:
- Macro: HILO_BYPASS_EN.
- Defined: hi_o/lo_o become combinational. When wb_whilo = 1 they show wb_hi/wb_lo, otherwise the stored HI/LO. The stored registers still update as above. EX then needs no separate WB forwarding path.
- Undefined: hi_o/lo_o are the stored registers directly. Behaviour is exactly as above, with 1 extra cycle of visibility delay.

Test Plan:
- Reset: assert rst for 2 edges with mem_wreg = 1, mem_wdata = 0xDEADBEEF -> all outputs 0, retire_cnt = 0.
- Passthrough: stall = 0, present mem_wd = 5, mem_wreg = 1, mem_wdata = 0x12345678 -> after 1 edge wb_wd = 5, wb_wreg = 1, wb_wdata = 0x12345678; retire_cnt = 1 after the next edge.
- HI/LO write: mem_whilo = 1, mem_hi = 0xAAAA0001, mem_lo = 0x5555000F -> wb_hi/wb_lo valid after edge 1, hi_o/lo_o = those values after edge 2. With HILO_BYPASS_EN, hi_o/lo_o equal them right after edge 1.
- Bubble: stall = 6'b010000 with mem_wreg = 1 -> wb_wreg = 0, wb_whilo = 0, wb_wdata = 0; retire_cnt unchanged; HI/LO unchanged.
- Hold: load wd = 7, wdata = 0x1; then stall = 6'b110000 for 3 edges while mem_* changes -> wb_* stays wd = 7, wdata = 0x1; retire_cnt increments only after stall[5] returns to 0 (+1 total).
- Wrap: preload retire_cnt near 0xFFFFFFFF (via a long run or forced value), retire 2 bundles -> counter reads 0xFFFFFFFF then 0x00000000.

Source files
------------

// File: rtl/mem_wb_hilo.sv
// MEM->WB pipeline register with architectural HI/LO storage and a debug retired-write counter.
// Latency: mem_* to wb_* in 1 cycle; mem_* to hi_o/lo_o in 2 cycles (1 with HILO_BYPASS_EN defined).
// Backpressure: stall[4] alone inserts a bubble, stall[5:4]=11 holds the WB bundle; stall[3:0] ignored.
module mem_wb_hilo #(
   parameter int REG_ADDR_W = 5,
   parameter int DATA_W     = 32,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [5:0]            stall,
   input  logic [REG_ADDR_W-1:0] mem_wd,
   input  logic                  mem_wreg,
   input  logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_hi,
   input  logic [DATA_W-1:0]     mem_lo,
   input  logic                  mem_whilo,
   output logic [REG_ADDR_W-1:0] wb_wd,
   output logic                  wb_wreg,
   output logic [DATA_W-1:0]     wb_wdata,
   output logic [DATA_W-1:0]     wb_hi,
   output logic [DATA_W-1:0]     wb_lo,
   output logic                  wb_whilo,
   output logic [DATA_W-1:0]     hi_o,
   output logic [DATA_W-1:0]     lo_o,
   output logic [CNT_W-1:0]      retire_cnt
);

   logic [REG_ADDR_W-1:0] wb_wd_q,    wb_wd_d;
   logic                  wb_wreg_q,  wb_wreg_d;
   logic [DATA_W-1:0]     wb_wdata_q, wb_wdata_d;
   logic [DATA_W-1:0]     wb_hi_q,    wb_hi_d;
   logic [DATA_W-1:0]     wb_lo_q,    wb_lo_d;
   logic                  wb_whilo_q, wb_whilo_d;
   logic [DATA_W-1:0]     hi_q,       hi_d;
   logic [DATA_W-1:0]     lo_q,       lo_d;
   logic [CNT_W-1:0]      retire_cnt_q, retire_cnt_d;

   // Lower stall bits belong to earlier stages and have no effect here.
   logic unused_stall;
   assign unused_stall = ^stall[3:0];

   // Next WB bundle: load when MEM advances, bubble when only MEM stops, otherwise hold.
   always_comb begin
      wb_wd_d    = wb_wd_q;
      wb_wreg_d  = wb_wreg_q;
      wb_wdata_d = wb_wdata_q;
      wb_hi_d    = wb_hi_q;
      wb_lo_d    = wb_lo_q;
      wb_whilo_d = wb_whilo_q;
      if (!stall[4]) begin
         wb_wd_d    = mem_wd;
         wb_wreg_d  = mem_wreg;
         wb_wdata_d = mem_wdata;
         wb_hi_d    = mem_hi;
         wb_lo_d    = mem_lo;
         wb_whilo_d = mem_whilo;
      end else if (!stall[5]) begin
         wb_wd_d    = '0;
         wb_wreg_d  = 1'b0;
         wb_wdata_d = '0;
         wb_hi_d    = '0;
         wb_lo_d    = '0;
         wb_whilo_d = 1'b0;
      end
   end

   // HI/LO commit from the bundle already sitting in WB; a held bundle rewrites identical values.
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (wb_whilo_q) begin
         hi_d = wb_hi_q;
         lo_d = wb_lo_q;
      end
   end

   // Count a bundle once, on the edge it actually leaves WB (never while WB is stopped).
   always_comb begin
      retire_cnt_d = retire_cnt_q;
      if ((wb_wreg_q | wb_whilo_q) && !stall[5]) begin
         retire_cnt_d = retire_cnt_q + CNT_W'(1);
      end
   end

   // State update with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_wd_q      <= '0;
         wb_wreg_q    <= 1'b0;
         wb_wdata_q   <= '0;
         wb_hi_q      <= '0;
         wb_lo_q      <= '0;
         wb_whilo_q   <= 1'b0;
         hi_q         <= '0;
         lo_q         <= '0;
         retire_cnt_q <= '0;
      end else begin
         wb_wd_q      <= wb_wd_d;
         wb_wreg_q    <= wb_wreg_d;
         wb_wdata_q   <= wb_wdata_d;
         wb_hi_q      <= wb_hi_d;
         wb_lo_q      <= wb_lo_d;
         wb_whilo_q   <= wb_whilo_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign wb_wd      = wb_wd_q;
   assign wb_wreg    = wb_wreg_q;
   assign wb_wdata   = wb_wdata_q;
   assign wb_hi      = wb_hi_q;
   assign wb_lo      = wb_lo_q;
   assign wb_whilo   = wb_whilo_q;
   assign retire_cnt = retire_cnt_q;

`ifdef HILO_BYPASS_EN
   // Expose the pending WB write early so EX can read HI/LO without its own WB forward.
   assign hi_o = wb_whilo_q ? wb_hi_q : hi_q;
   assign lo_o = wb_whilo_q ? wb_lo_q : lo_q;
`else
   assign hi_o = hi_q;
   assign lo_o = lo_q;
`endif

endmodule

// File: tb/tb_mem_wb_hilo.sv
// Testbench for mem_wb_hilo: directed steps then random traffic against a bundle-level model.
// A second instance with a 4-bit counter exercises counter wrap in few cycles.
// Outputs are sampled 1 time unit after each rising edge.
module tb_mem_wb_hilo;

   typedef struct packed {
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        whilo;
   } bundle_t;

`ifdef HILO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [5:0]  stall;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata, mem_hi, mem_lo;
   logic        mem_whilo;

   logic [4:0]  wb_wd;
   logic        wb_wreg, wb_whilo;
   logic [31:0] wb_wdata, wb_hi, wb_lo, hi_o, lo_o, retire_cnt;

   logic [4:0]  s_wb_wd;
   logic        s_wb_wreg, s_wb_whilo;
   logic [31:0] s_wb_wdata, s_wb_hi, s_wb_lo, s_hi_o, s_lo_o;
   logic [3:0]  s_retire_cnt;

   int vectors = 0;
   int miscompares = 0;

   // Reference state: the bundle in WB, committed HI/LO and retire counts.
   bundle_t     wb_m;
   logic [31:0] hi_m, lo_m, cnt_m;
   logic [3:0]  cnt_s_m;

   mem_wb_hilo #(.REG_ADDR_W(5), .DATA_W(32), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
      .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
      .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
      .hi_o(hi_o), .lo_o(lo_o), .retire_cnt(retire_cnt)
   );

   mem_wb_hilo #(.REG_ADDR_W(5), .DATA_W(32), .CNT_W(4)) dut_small (
      .clk(clk), .rst(rst), .stall(stall),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
      .wb_wd(s_wb_wd), .wb_wreg(s_wb_wreg), .wb_wdata(s_wb_wdata),
      .wb_hi(s_wb_hi), .wb_lo(s_wb_lo), .wb_whilo(s_wb_whilo),
      .hi_o(s_hi_o), .lo_o(s_lo_o), .retire_cnt(s_retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not reach its end (got running, need finished)");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic check_model(input string ph);
      logic [31:0] exp_hi, exp_lo;
      exp_hi = (BYP && wb_m.whilo) ? wb_m.hi : hi_m;
      exp_lo = (BYP && wb_m.whilo) ? wb_m.lo : lo_m;
      check({ph, ".wb_wd"},    32'(wb_wd),    32'(wb_m.wd));
      check({ph, ".wb_wreg"},  32'(wb_wreg),  32'(wb_m.wreg));
      check({ph, ".wb_wdata"}, wb_wdata,      wb_m.wdata);
      check({ph, ".wb_hi"},    wb_hi,         wb_m.hi);
      check({ph, ".wb_lo"},    wb_lo,         wb_m.lo);
      check({ph, ".wb_whilo"}, 32'(wb_whilo), 32'(wb_m.whilo));
      check({ph, ".hi_o"},     hi_o,          exp_hi);
      check({ph, ".lo_o"},     lo_o,          exp_lo);
      check({ph, ".retire_cnt"}, retire_cnt,  cnt_m);
      check({ph, ".small_cnt"},  32'(s_retire_cnt), 32'(cnt_s_m));
   endtask

   // Advance one clock: work out the expected post-edge state from the pre-edge inputs, then compare.
   task automatic tick(input string ph);
      bundle_t     n_wb;
      logic [31:0] n_hi, n_lo, n_cnt;
      logic [3:0]  n_cnt_s;
      bit          retiring;
      if (rst) begin
         n_wb = '0; n_hi = 0; n_lo = 0; n_cnt = 0; n_cnt_s = 0;
      end else begin
         n_hi = wb_m.whilo ? wb_m.hi : hi_m;
         n_lo = wb_m.whilo ? wb_m.lo : lo_m;
         retiring = (wb_m.wreg || wb_m.whilo) && !stall[5];
         n_cnt   = retiring ? cnt_m + 1 : cnt_m;
         n_cnt_s = retiring ? cnt_s_m + 4'd1 : cnt_s_m;
         if (!stall[4]) begin
            n_wb.wd = mem_wd; n_wb.wreg = mem_wreg; n_wb.wdata = mem_wdata;
            n_wb.hi = mem_hi; n_wb.lo = mem_lo; n_wb.whilo = mem_whilo;
         end else if (!stall[5]) begin
            n_wb = '0;
         end else begin
            n_wb = wb_m;
         end
      end
      @(posedge clk);
      #1;
      wb_m = n_wb; hi_m = n_hi; lo_m = n_lo; cnt_m = n_cnt; cnt_s_m = n_cnt_s;
      check_model(ph);
   endtask

   task automatic idle_inputs();
      mem_wd = 0; mem_wreg = 0; mem_wdata = 0; mem_hi = 0; mem_lo = 0; mem_whilo = 0;
   endtask

   initial begin
      wb_m = '0; hi_m = 0; lo_m = 0; cnt_m = 0; cnt_s_m = 0;
      stall = 0;
      idle_inputs();

      // Reset with a live bundle on the inputs.
      rst = 1; mem_wreg = 1; mem_wdata = 32'hDEADBEEF;
      #3;
      tick("reset1");
      tick("reset2");
      check("reset.wb_wreg", 32'(wb_wreg), 32'd0);
      check("reset.wb_wdata", wb_wdata, 32'd0);
      check("reset.retire_cnt", retire_cnt, 32'd0);
      check("reset.hi_o", hi_o, 32'd0);

      // Passthrough.
      rst = 0; idle_inputs();
      mem_wd = 5; mem_wreg = 1; mem_wdata = 32'h12345678;
      tick("pass1");
      check("pass.wb_wd", 32'(wb_wd), 32'd5);
      check("pass.wb_wreg", 32'(wb_wreg), 32'd1);
      check("pass.wb_wdata", wb_wdata, 32'h12345678);
      check("pass.cnt_before", retire_cnt, 32'd0);
      idle_inputs();
      tick("pass2");
      check("pass.cnt_after", retire_cnt, 32'd1);

      // HI/LO write.
      mem_whilo = 1; mem_hi = 32'hAAAA0001; mem_lo = 32'h5555000F;
      tick("hilo1");
      check("hilo.wb_hi", wb_hi, 32'hAAAA0001);
      check("hilo.wb_lo", wb_lo, 32'h5555000F);
      check("hilo.hi_edge1", hi_o, BYP ? 32'hAAAA0001 : 32'd0);
      idle_inputs();
      tick("hilo2");
      check("hilo.hi_edge2", hi_o, 32'hAAAA0001);
      check("hilo.lo_edge2", lo_o, 32'h5555000F);
      check("hilo.cnt", retire_cnt, 32'd2);

      // Bubble.
      stall = 6'b010000; mem_wd = 9; mem_wreg = 1; mem_wdata = 32'hCAFEF00D; mem_whilo = 1;
      mem_hi = 32'h11111111; mem_lo = 32'h22222222;
      tick("bubble");
      check("bubble.wb_wreg", 32'(wb_wreg), 32'd0);
      check("bubble.wb_whilo", 32'(wb_whilo), 32'd0);
      check("bubble.wb_wdata", wb_wdata, 32'd0);
      check("bubble.cnt", retire_cnt, 32'd2);
      check("bubble.hi_o", hi_o, 32'hAAAA0001);

      // Hold.
      stall = 0; idle_inputs(); mem_wd = 7; mem_wreg = 1; mem_wdata = 32'h1;
      tick("hold_load");
      stall = 6'b110000;
      for (int i = 0; i < 3; i++) begin
         mem_wd = 5'(i + 10); mem_wdata = $urandom; mem_wreg = 1;
         tick("hold");
         check("hold.wb_wd", 32'(wb_wd), 32'd7);
         check("hold.wb_wdata", wb_wdata, 32'h1);
         check("hold.cnt", retire_cnt, 32'd2);
      end
      stall = 0; idle_inputs();
      tick("hold_release");
      check("hold.cnt_release", retire_cnt, 32'd3);

      // Counter wrap on the 4-bit instance: first edge after reset loads, later edges retire.
      rst = 1; tick("wrap_rst"); rst = 0;
      mem_wreg = 1;
      for (int i = 0; i < 16; i++) tick("wrap_run");
      check("wrap.small_ones", 32'(s_retire_cnt), 32'hF);
      tick("wrap_edge");
      check("wrap.small_zero", 32'(s_retire_cnt), 32'h0);

      // Random traffic, including resets mid-stall.
      for (int i = 0; i < 400; i++) begin
         rst       = ($urandom_range(0, 39) == 0);
         stall     = 6'($urandom);
         mem_wd    = 5'($urandom);
         mem_wreg  = 1'($urandom);
         mem_wdata = $urandom;
         mem_hi    = $urandom;
         mem_lo    = $urandom;
         mem_whilo = 1'($urandom);
         tick("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
